// File: rtl/elevator_switch_ctrl.sv
// Pressure-plate / lever controller feeding the elevator block.
// Debounces player occupancy on frame ticks and renders the sinking switch sprite.
module elevator_switch_ctrl #(
  parameter int SWITCH_X        = 100,
  parameter int SWITCH_Y        = 300,
  parameter int SWITCH_WIDTH    = 32,
  parameter int SWITCH_HEIGHT   = 8,
  parameter int DEBOUNCE_FRAMES = 3,
  parameter int MAX_DEPTH       = 4,
  parameter int LATCH_MODE      = 0
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               frame_clk,
  input  logic signed [15:0] player1_top,
  input  logic signed [15:0] player1_bottom,
  input  logic signed [15:0] player1_left,
  input  logic signed [15:0] player1_right,
  input  logic signed [15:0] player2_top,
  input  logic signed [15:0] player2_bottom,
  input  logic signed [15:0] player2_left,
  input  logic signed [15:0] player2_right,
  input  logic [9:0]         DrawX,
  input  logic [9:0]         DrawY,
  output logic               elevator_on,
  output logic               on_pulse,
  output logic               is_switch,
  output logic [9:0]         switch_read_addr,
  output logic [2:0]         switch_depth
);

  typedef enum logic [1:0] {IDLE, ARMING, ACTIVE, DISARMING} state_t;

  localparam logic signed [15:0] X_LO  = 16'(SWITCH_X);
  localparam logic signed [15:0] X_HI  = 16'(SWITCH_X + SWITCH_WIDTH);
  localparam logic signed [15:0] Y_LO  = 16'(SWITCH_Y - 1);
  localparam logic signed [15:0] Y_HI  = 16'(SWITCH_Y + SWITCH_HEIGHT);
  localparam logic signed [15:0] Y_TOP = 16'(SWITCH_Y);
  localparam logic signed [15:0] W_S   = 16'(SWITCH_WIDTH);
  localparam logic signed [15:0] H_S   = 16'(SWITCH_HEIGHT);
  localparam logic [9:0]         W_10  = 10'(SWITCH_WIDTH);
  localparam logic [2:0]         DEB   = 3'(DEBOUNCE_FRAMES);
  localparam logic [2:0]         MAX_D = 3'(MAX_DEPTH);
  localparam bit                 DF_ONE = (DEBOUNCE_FRAMES == 1);

  state_t state, next_state;
  logic [2:0] count, next_count, count_inc;
  logic frame_clk_delayed, tick;
  logic occ, p1_occ, p2_occ;
  logic next_on, enter_active, enter_idle;
  logic [2:0] next_depth;
  logic signed [15:0] off_x, off_y, vis_h;
  logic unused_tops;

  // Head height plays no part in standing on the plate.
  assign unused_tops = ^{player1_top, player2_top};

  function automatic logic on_plate(input logic signed [15:0] left,
                                    input logic signed [15:0] right,
                                    input logic signed [15:0] bottom);
    return (right > X_LO) && (left < X_HI) && (bottom >= Y_LO) && (bottom <= Y_HI);
  endfunction

  assign p1_occ    = on_plate(player1_left, player1_right, player1_bottom);
  assign p2_occ    = on_plate(player2_left, player2_right, player2_bottom);
  assign occ       = p1_occ | p2_occ;
  assign count_inc = count + 3'd1;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      frame_clk_delayed <= 1'b0;
      tick              <= 1'b0;
    end else begin
      frame_clk_delayed <= frame_clk;
      tick              <= frame_clk & ~frame_clk_delayed;
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state <= IDLE;
      count <= 3'd0;
    end else if (tick) begin
      state <= next_state;
      count <= next_count;
    end
  end

  always_comb begin
    next_state = state;
    next_count = count;
    case (state)
      IDLE: begin
        if (occ) begin
          next_state = DF_ONE ? ACTIVE : ARMING;
          next_count = DF_ONE ? 3'd0 : 3'd1;
        end
      end
      ARMING: begin
        if (!occ) begin
          next_state = IDLE;
          next_count = 3'd0;
        end else if (count_inc == DEB) begin
          next_state = ACTIVE;
          next_count = 3'd0;
        end else begin
          next_count = count_inc;
        end
      end
      ACTIVE: begin
        if (!occ) begin
          next_state = DF_ONE ? IDLE : DISARMING;
          next_count = DF_ONE ? 3'd0 : 3'd1;
        end
      end
      DISARMING: begin
        if (occ) begin
          next_state = ACTIVE;
          next_count = 3'd0;
        end else if (count_inc == DEB) begin
          next_state = IDLE;
          next_count = 3'd0;
        end else begin
          next_count = count_inc;
        end
      end
      default: begin
        next_state = IDLE;
        next_count = 3'd0;
      end
    endcase
  end

  // Plate sinks whenever the debouncer is heading towards or holding the pressed state.
  always_comb begin
    enter_active = (next_state == ACTIVE) && (state != ACTIVE);
    enter_idle   = (next_state == IDLE) && (state != IDLE);
    next_on      = elevator_on;
    if (LATCH_MODE != 0) begin
      if (enter_active) next_on = ~elevator_on;
    end else begin
      if (enter_active)    next_on = 1'b1;
      else if (enter_idle) next_on = 1'b0;
    end
    if (next_state == ARMING || next_state == ACTIVE)
      next_depth = (switch_depth >= MAX_D) ? MAX_D : switch_depth + 3'd1;
    else
      next_depth = (switch_depth == 3'd0) ? 3'd0 : switch_depth - 3'd1;
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      elevator_on  <= 1'b0;
      on_pulse     <= 1'b0;
      switch_depth <= 3'd0;
    end else begin
      on_pulse <= tick & (next_on ^ elevator_on);
      if (tick) begin
        elevator_on  <= next_on;
        switch_depth <= next_depth;
      end
    end
  end

  // The sprite's top edge moves down with the plate and its visible height shrinks to match.
  assign off_x = $signed({6'd0, DrawX}) - X_LO;
  assign off_y = $signed({6'd0, DrawY}) - (Y_TOP + $signed({13'd0, switch_depth}));
  assign vis_h = H_S - $signed({13'd0, switch_depth});

  assign is_switch = (off_x >= 16'sd0) && (off_x < W_S) &&
                     (off_y >= 16'sd0) && (off_y < vis_h);
  assign switch_read_addr = is_switch ? (off_x[9:0] + off_y[9:0] * W_10) : 10'd0;

endmodule

// File: tb/tb_elevator_switch_ctrl.sv
// Bench for elevator_switch_ctrl: momentary and latching instances checked every cycle
// against a run-length occupancy model, plus directed literal expectations.
module tb_elevator_switch_ctrl;

  localparam int SX = 100, SY = 300, SW = 32, SH = 8, DF = 3, MAXD = 4;

  logic Clk = 1'b0;
  logic Reset, frame_clk;
  shortint p1t, p1b, p1l, p1r, p2t, p2b, p2l, p2r;
  logic [9:0] DrawX, DrawY;
  logic eo[2], op[2], hit[2];
  logic [9:0] addr[2];
  logic [2:0] dep[2];

  int vectors = 0;
  int miscompares = 0;
  bit check_en = 1'b0;
  int pulses[2] = '{0, 0};

  elevator_switch_ctrl #(.LATCH_MODE(0)) u_mom (
    .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk),
    .player1_top(p1t), .player1_bottom(p1b), .player1_left(p1l), .player1_right(p1r),
    .player2_top(p2t), .player2_bottom(p2b), .player2_left(p2l), .player2_right(p2r),
    .DrawX(DrawX), .DrawY(DrawY),
    .elevator_on(eo[0]), .on_pulse(op[0]), .is_switch(hit[0]),
    .switch_read_addr(addr[0]), .switch_depth(dep[0]));

  elevator_switch_ctrl #(.LATCH_MODE(1)) u_lat (
    .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk),
    .player1_top(p1t), .player1_bottom(p1b), .player1_left(p1l), .player1_right(p1r),
    .player2_top(p2t), .player2_bottom(p2b), .player2_left(p2l), .player2_right(p2r),
    .DrawX(DrawX), .DrawY(DrawY),
    .elevator_on(eo[1]), .on_pulse(op[1]), .is_switch(hit[1]),
    .switch_read_addr(addr[1]), .switch_depth(dep[1]));

  always #5 Clk = ~Clk;

  // Model: debounced "pressed" level plus the length of the current disagreeing run.
  logic m_fd, m_tick, m_pressed, m_occ, m_np, m_enter;
  int m_run, m_nr, m_depth, m_nd;
  logic m_on[2], m_non[2], m_pulse[2];

  function automatic logic occ_of(int l, int r, int b);
    return (r > SX) && (l < SX + SW) && (b >= SY - 1) && (b <= SY + SH);
  endfunction

  function automatic logic [10:0] sprite_of(int dx, int dy, int d);
    int ox, oy;
    ox = dx - SX;
    oy = dy - (SY + d);
    if (ox >= 0 && ox < SW && oy >= 0 && oy < SH - d) return {1'b1, 10'(ox + oy * SW)};
    return 11'd0;
  endfunction

  always_comb begin
    m_occ   = occ_of(p1l, p1r, p1b) | occ_of(p2l, p2r, p2b);
    m_np    = m_pressed;
    m_nr    = 0;
    m_enter = 1'b0;
    if (m_occ == m_pressed) begin
      m_enter = m_occ && (m_run > 0);
    end else begin
      m_nr = m_run + 1;
      if (m_nr == DF) begin
        m_np    = ~m_pressed;
        m_nr    = 0;
        m_enter = m_np;
      end
    end
    m_non[0] = m_np;
    m_non[1] = m_enter ? ~m_on[1] : m_on[1];
    if (m_occ) m_nd = (m_depth < MAXD) ? m_depth + 1 : MAXD;
    else       m_nd = (m_depth > 0) ? m_depth - 1 : 0;
  end

  always @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      m_fd <= 1'b0; m_tick <= 1'b0; m_pressed <= 1'b0; m_run <= 0; m_depth <= 0;
      m_on[0] <= 1'b0; m_on[1] <= 1'b0; m_pulse[0] <= 1'b0; m_pulse[1] <= 1'b0;
    end else begin
      m_fd       <= frame_clk;
      m_tick     <= frame_clk & ~m_fd;
      m_pulse[0] <= 1'b0;
      m_pulse[1] <= 1'b0;
      if (m_tick) begin
        m_pressed  <= m_np;
        m_run      <= m_nr;
        m_depth    <= m_nd;
        m_on[0]    <= m_non[0];
        m_on[1]    <= m_non[1];
        m_pulse[0] <= m_non[0] ^ m_on[0];
        m_pulse[1] <= m_non[1] ^ m_on[1];
      end
    end
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    vectors++;
    if (actual != expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input int l1, input int r1, input int b1,
                               input int l2, input int r2, input int b2);
    p1l = shortint'(l1); p1r = shortint'(r1); p1b = shortint'(b1); p1t = shortint'(b1 - 40);
    p2l = shortint'(l2); p2r = shortint'(r2); p2b = shortint'(b2); p2t = shortint'(b2 - 40);
  endtask

  task automatic frame_tick();
    @(negedge Clk) frame_clk = 1'b1;
    repeat (2) @(negedge Clk);
    frame_clk = 1'b0;
    repeat (2) @(negedge Clk);
  endtask

  task automatic reset_pulse();
    @(negedge Clk) Reset = 1'b0;
    repeat (2) @(negedge Clk);
    Reset = 1'b1;
  endtask

  always @(negedge Clk) begin
    if (op[0]) pulses[0] <= pulses[0] + 1;
    if (op[1]) pulses[1] <= pulses[1] + 1;
  end

  always @(negedge Clk) begin
    if (check_en) begin
      for (int i = 0; i < 2; i++) begin
        checkOutput($sformatf("elevator_on[%0d]", i), int'(eo[i]), int'(m_on[i]));
        checkOutput($sformatf("on_pulse[%0d]", i), int'(op[i]), int'(m_pulse[i]));
        checkOutput($sformatf("depth[%0d]", i), int'(dep[i]), m_depth);
        checkOutput($sformatf("is_switch[%0d]", i), int'(hit[i]),
                    int'(sprite_of(int'(DrawX), int'(DrawY), m_depth) >> 10));
        checkOutput($sformatf("addr[%0d]", i), int'(addr[i]),
                    int'(sprite_of(int'(DrawX), int'(DrawY), m_depth) & 11'h3FF));
      end
    end
  end

  int exp_d[5]  = '{1, 2, 3, 4, 4};
  int exp_on[5] = '{0, 0, 1, 1, 1};
  int lat_on[20] = '{0,0,1,1,1, 1,1,1,1,1, 1,1,0,0,0, 0,0,0,0,0};
  int snap0, snap1;

  initial begin
    Reset = 1'b1; frame_clk = 1'b0; DrawX = 10'd0; DrawY = 10'd0;
    applyStimulus(500, 520, 300, 600, 620, 300);
    #1 Reset = 1'b0;
    repeat (3) @(negedge Clk);
    check_en = 1'b1;
    checkOutput("reset elevator_on", int'(eo[0]), 0);
    checkOutput("reset depth", int'(dep[0]), 0);
    Reset = 1'b1;

    $display("[TB] idle ticks");
    snap0 = pulses[0]; snap1 = pulses[1];
    repeat (10) frame_tick();
    checkOutput("idle pulses mom", pulses[0] - snap0, 0);
    checkOutput("idle pulses lat", pulses[1] - snap1, 0);
    checkOutput("idle depth", int'(dep[0]), 0);

    $display("[TB] press player1");
    snap0 = pulses[0];
    applyStimulus(110, 130, 300, 600, 620, 300);
    for (int t = 0; t < 5; t++) begin
      frame_tick();
      checkOutput($sformatf("press depth t%0d", t + 1), int'(dep[0]), exp_d[t]);
      checkOutput($sformatf("press on t%0d", t + 1), int'(eo[0]), exp_on[t]);
    end
    checkOutput("press pulses", pulses[0] - snap0, 1);

    $display("[TB] handover to player2");
    applyStimulus(110, 130, 300, 120, 140, 299);
    frame_tick();
    applyStimulus(80, 100, 300, 120, 140, 299);
    frame_tick();
    checkOutput("handover on", int'(eo[0]), 1);
    checkOutput("handover depth", int'(dep[0]), 4);

    $display("[TB] bounce");
    snap0 = pulses[0];
    applyStimulus(80, 100, 300, 120, 140, 309);
    frame_tick();
    checkOutput("bounce leave depth", int'(dep[0]), 3);
    applyStimulus(110, 130, 300, 600, 620, 300);
    frame_tick();
    checkOutput("bounce return on", int'(eo[0]), 1);
    checkOutput("bounce return depth", int'(dep[0]), 4);
    checkOutput("bounce pulses", pulses[0] - snap0, 0);

    $display("[TB] release");
    applyStimulus(500, 520, 300, 600, 620, 300);
    for (int t = 0; t < 3; t++) frame_tick();
    checkOutput("release on", int'(eo[0]), 0);
    checkOutput("release depth", int'(dep[0]), 1);
    checkOutput("release pulses", pulses[0] - snap0, 1);
    repeat (3) frame_tick();
    checkOutput("release depth floor", int'(dep[0]), 0);

    $display("[TB] lever toggling");
    reset_pulse();
    snap1 = pulses[1];
    for (int t = 0; t < 20; t++) begin
      if ((t / 5) % 2 == 0) applyStimulus(110, 130, 305, 600, 620, 300);
      else                  applyStimulus(500, 520, 300, 600, 620, 300);
      frame_tick();
      checkOutput($sformatf("lever on t%0d", t + 1), int'(eo[1]), lat_on[t]);
    end
    checkOutput("lever pulses", pulses[1] - snap1, 2);

    $display("[TB] sprite at depth 2");
    reset_pulse();
    applyStimulus(110, 130, 300, 600, 620, 300);
    repeat (2) frame_tick();
    checkOutput("sprite depth", int'(dep[0]), 2);
    DrawX = 10'd100; DrawY = 10'd302; #1;
    checkOutput("sprite hit corner", int'(hit[0]), 1);
    checkOutput("sprite addr corner", int'(addr[0]), 0);
    DrawX = 10'd131; DrawY = 10'd307; #1;
    checkOutput("sprite hit far", int'(hit[0]), 1);
    checkOutput("sprite addr far", int'(addr[0]), 191);
    DrawY = 10'd308; #1;
    checkOutput("sprite hit below", int'(hit[0]), 0);
    checkOutput("sprite addr below", int'(addr[0]), 0);
    DrawX = 10'd99; DrawY = 10'd302; #1;
    checkOutput("sprite hit left", int'(hit[0]), 0);
    @(negedge Clk);

    $display("[TB] async reset mid-debounce");
    DrawX = 10'd0; DrawY = 10'd0;
    #3 Reset = 1'b0;
    #1;
    checkOutput("async on", int'(eo[0]), 0);
    checkOutput("async pulse", int'(op[0]), 0);
    checkOutput("async depth", int'(dep[0]), 0);
    checkOutput("async hit", int'(hit[0]), 0);
    @(negedge Clk) Reset = 1'b1;
    repeat (2) frame_tick();
    checkOutput("redebounce on t2", int'(eo[0]), 0);
    frame_tick();
    checkOutput("redebounce on t3", int'(eo[0]), 1);

    repeat (2) @(negedge Clk);
    check_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
